rx_frame_ctrl: RTL

- Receive-side controller sitting directly behind the HDLC deframer in the netclk domain.
- Detects the deframer's byte/frame-end/abort events and writes received bytes into a slotted packet RAM (external, single write port).
- Commits good frames as descriptors to the host-side logic and recycles slots on host release.
- Strips the 2 FCS bytes; discards CRC-bad, aborted, runt and oversize frames.

---
 rtl/rx_frame_ctrl_pkg.sv | 33 +++
 rtl/rx_desc_fifo.sv | 56 +++++
 rtl/rx_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_ctrl_pkg.sv
// rx_frame_ctrl shared types and width helpers.
// FSM encoding, FCS size and saturating counter step.
package rx_frame_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        RECV   = 4'b0010,
        COMMIT = 4'b0100,
        DROP   = 4'b1000
    } state_t;

    localparam int FCS_BYTES = 2;

    function automatic int slot_w(input int slots);
        return $clog2(slots);
    endfunction

    function automatic int off_w(input int bytes);
        return $clog2(bytes);
    endfunction

    function automatic int len_w(input int bytes);
        return $clog2(bytes) + 1;
    endfunction

    function automatic logic [15:0] sat_inc(
        input logic [15:0] v,
        input logic        en
    );
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/rx_desc_fifo.sv
// Small synchronous FIFO with push strobe and valid/ready pop.
// Head entry is shown directly on data while valid is high.
module rx_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (fill == (AW+1)'(DEPTH));
    assign valid   = (fill != '0);
    assign do_pop  = valid && ready;
    assign do_push = push && !full;
    assign data    = mem[rd_ptr];

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill <= fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: deframer events to slotted packet RAM.
// Event counters built only with RX_FRAME_CTRL_STATS_EN defined.
module rx_frame_ctrl
    import rx_frame_ctrl_pkg::*;
#(
    parameter int SLOTS      = 4,
    parameter int SLOT_BYTES = 256,
    parameter int MIN_LEN    = 4
) (
    input  logic                                   netclk,
    input  logic                                   reset,
    input  logic                                   rx_byte_ready,
    input  logic [7:0]                             rx_byte,
    input  logic                                   rx_frame_complete,
    input  logic                                   rx_frame_valid,
    input  logic                                   rx_frame_abort,
    output logic                                   ram_we,
    output logic [slot_w(SLOTS)+off_w(SLOT_BYTES)-1:0] ram_addr,
    output logic [7:0]                             ram_wdata,
    output logic                                   desc_valid,
    input  logic                                   desc_ready,
    output logic [slot_w(SLOTS)-1:0]               desc_slot,
    output logic [len_w(SLOT_BYTES)-1:0]           desc_len,
    input  logic                                   free_valid,
    input  logic [slot_w(SLOTS)-1:0]               free_slot,
    output logic                                   busy,
    output logic [15:0]                            stat_good,
    output logic [15:0]                            stat_crc,
    output logic [15:0]                            stat_abort,
    output logic [15:0]                            stat_drop
);

    localparam int SW = slot_w(SLOTS);
    localparam int OW = off_w(SLOT_BYTES);
    localparam int LW = len_w(SLOT_BYTES);

    state_t          state;
    state_t          state_nx;
    logic            byte_q;
    logic            fe_q;
    logic            ab_q;
    logic            byte_ev;
    logic            fe_ev;
    logic            ab_ev;
    logic            valid_q;
    logic [SW-1:0]   slot;
    logic [SW-1:0]   slot_nx;
    logic [LW-1:0]   count;
    logic [LW-1:0]   count_nx;
    logic [LW:0]     len_s;
    logic [SLOTS-1:0] free_map;
    logic [SLOTS-1:0] free_nx;
    logic [SW-1:0]   low_free;
    logic            have_free;
    logic            we_nx;
    logic [SW+OW-1:0] waddr;
    logic            alloc;
    logic            rel;
    logic            push;
    logic            inc_good;
    logic            inc_crc;
    logic            inc_abort;
    logic            inc_drop;
    logic [SW+LW-1:0] desc_data;

    assign byte_ev = rx_byte_ready & ~byte_q;
    assign fe_ev   = rx_frame_complete & ~fe_q;
    assign ab_ev   = rx_frame_abort & ~ab_q;
    assign busy    = state[1] | state[3];

    // length with a sign bit so a 0/1-byte frame reads as negative
    assign len_s = {1'b0, count} - (LW+1)'(FCS_BYTES);

    // lowest-index free slot
    always_comb begin
        have_free = |free_map;
        low_free  = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                low_free = SW'(i);
            end
        end
    end

    // next state; abort beats frame end beats byte
    always_comb begin
        state_nx  = state;
        slot_nx   = slot;
        count_nx  = count;
        we_nx     = 1'b0;
        waddr     = {slot, count[OW-1:0]};
        alloc     = 1'b0;
        rel       = 1'b0;
        push      = 1'b0;
        inc_good  = 1'b0;
        inc_crc   = 1'b0;
        inc_abort = 1'b0;
        inc_drop  = 1'b0;
        unique case (state)
            IDLE: begin
                if (byte_ev) begin
                    if (have_free) begin
                        alloc    = 1'b1;
                        slot_nx  = low_free;
                        we_nx    = 1'b1;
                        waddr    = {low_free, {OW{1'b0}}};
                        count_nx = LW'(1);
                        state_nx = RECV;
                    end else begin
                        inc_drop = 1'b1;
                        state_nx = DROP;
                    end
                end
            end
            RECV: begin
                if (ab_ev) begin
                    rel       = 1'b1;
                    inc_abort = 1'b1;
                    state_nx  = IDLE;
                end else if (fe_ev) begin
                    state_nx = COMMIT;
                end else if (byte_ev) begin
                    if (count == LW'(SLOT_BYTES)) begin
                        rel      = 1'b1;
                        inc_drop = 1'b1;
                        state_nx = DROP;
                    end else begin
                        we_nx    = 1'b1;
                        count_nx = count + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_nx = IDLE;
                if (valid_q && !len_s[LW] &&
                    len_s[LW-1:0] >= LW'(MIN_LEN)) begin
                    push     = 1'b1;
                    inc_good = 1'b1;
                end else begin
                    rel      = 1'b1;
                    inc_crc  = !valid_q;
                    inc_drop = valid_q;
                end
            end
            DROP: begin
                if (ab_ev || fe_ev) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // slot bitmap; allocation sees the pre-release map
    always_comb begin
        free_nx = free_map;
        if (free_valid && !(state == RECV && free_slot == slot)) begin
            free_nx[free_slot] = 1'b1;
        end
        if (rel) begin
            free_nx[slot] = 1'b1;
        end
        if (alloc) begin
            free_nx[low_free] = 1'b0;
        end
    end

    // state register
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // edge samples, frame context, slot map and RAM write port
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            byte_q    <= 1'b0;
            fe_q      <= 1'b0;
            ab_q      <= 1'b0;
            valid_q   <= 1'b0;
            slot      <= '0;
            count     <= '0;
            free_map  <= '1;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            byte_q   <= rx_byte_ready;
            fe_q     <= rx_frame_complete;
            ab_q     <= rx_frame_abort;
            if (fe_ev) begin
                valid_q <= rx_frame_valid;
            end
            slot     <= slot_nx;
            count    <= count_nx;
            free_map <= free_nx;
            ram_we   <= we_nx;
            if (we_nx) begin
                ram_addr  <= waddr;
                ram_wdata <= rx_byte;
            end
        end
    end

    rx_desc_fifo #(
        .DEPTH (SLOTS),
        .WIDTH (SW + LW)
    ) u_desc_fifo (
        .clk       (netclk),
        .reset     (reset),
        .push      (push),
        .push_data ({slot, len_s[LW-1:0]}),
        .valid     (desc_valid),
        .ready     (desc_ready),
        .data      (desc_data)
    );

    assign {desc_slot, desc_len} = desc_data;

`ifdef RX_FRAME_CTRL_STATS_EN
    logic [15:0] good_c;
    logic [15:0] crc_c;
    logic [15:0] abort_c;
    logic [15:0] drop_c;

    // saturating event counters
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            good_c  <= '0;
            crc_c   <= '0;
            abort_c <= '0;
            drop_c  <= '0;
        end else begin
            good_c  <= sat_inc(good_c, inc_good);
            crc_c   <= sat_inc(crc_c, inc_crc);
            abort_c <= sat_inc(abort_c, inc_abort);
            drop_c  <= sat_inc(drop_c, inc_drop);
        end
    end

    assign stat_good  = good_c;
    assign stat_crc   = crc_c;
    assign stat_abort = abort_c;
    assign stat_drop  = drop_c;
`else
    logic unused_stats;
    assign unused_stats = ^{inc_good, inc_crc, inc_abort, inc_drop};
    assign stat_good  = '0;
    assign stat_crc   = '0;
    assign stat_abort = '0;
    assign stat_drop  = '0;
`endif

endmodule
